proc_fetch_unit: RTL

- F-stage fetch engine sitting directly upstream of the 5-stage datapath's D-stage instruction register.
- Owns the fetch PC and issues pipelined instruction-memory requests over a val/rdy handshake.
- Delivers instruction/PC pairs to decode over a val/rdy handshake.
- On a redirect from D (jal) or X (branch/jalr), squashes in-flight responses with a drop counter.

---
 rtl/proc_fetch_pkg.sv | 15 +
 rtl/proc_fetch_pc_queue.sv | 49 ++++
 rtl/proc_fetch_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/proc_fetch_pkg.sv
// Shared constants and types for the F-stage fetch engine.
package proc_fetch_pkg;

    localparam logic [31:0] c_reset_vector = 32'h0000_0200;
    localparam logic [31:0] c_nop          = 32'h0000_0013;
    localparam int          c_max_inflight = 2;

    typedef logic [$clog2(c_max_inflight):0] fetch_cnt_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_pair_t;

endpackage

// File: rtl/proc_fetch_pc_queue.sv
// Circular FIFO of issued fetch PCs, one entry per outstanding imem request.
module proc_fetch_pc_queue #(
    parameter int p_depth = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic        full,
    output logic        empty
);

    localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int CW = $clog2(p_depth) + 1;
    localparam logic [PW-1:0] LAST      = PW'(p_depth - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(p_depth);

    logic [31:0]   mem [p_depth];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_push, do_pop;

    // A pop frees the slot in the same cycle, so push is legal when full
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/proc_fetch_unit.sv
// F-stage fetch engine: owns the fetch PC, pipelines imem requests and squashes
// stale responses after a redirect.
module proc_fetch_unit
    import proc_fetch_pkg::*;
#(
    parameter logic [31:0] p_reset_vector = c_reset_vector,
    parameter int          p_max_inflight = c_max_inflight
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemreq_val,
    input  logic        imemreq_rdy,
    output logic [31:0] imemreq_addr,
    input  logic        imemresp_val,
    output logic        imemresp_rdy,
    input  logic [31:0] imemresp_data,
    input  logic        redirect_val,
    input  logic [31:0] redirect_target,
    output logic        inst_val_F,
    input  logic        inst_rdy_D,
    output logic [31:0] inst_F,
    output logic [31:0] pc_F
);

    localparam int CW = $clog2(p_max_inflight) + 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t MAX_CNT = CW'(p_max_inflight);

    logic [31:0] fetch_pc;
    cnt_t        inflight_cnt, drop_cnt;
    logic [31:0] q_head;
    logic        q_full, q_empty;
    logic        req_fire, resp_fire, deliver;
    fetch_pair_t out_pair;

    assign imemreq_val  = !reset && (inflight_cnt < MAX_CNT) && !q_full;
    assign imemreq_addr = reset ? '0 : (redirect_val ? redirect_target : fetch_pc);
    assign req_fire     = imemreq_val && imemreq_rdy;

    // Squash and redirect both swallow the response; only a clean cycle
    // passes it to decode under decode's backpressure.
    always_comb begin
        imemresp_rdy = 1'b0;
        deliver      = 1'b0;
        if (reset) begin
            imemresp_rdy = 1'b0;
        end else if (drop_cnt != '0 || redirect_val) begin
            imemresp_rdy = 1'b1;
        end else begin
            imemresp_rdy = inst_rdy_D;
            deliver      = 1'b1;
        end
    end

    assign resp_fire = imemresp_val && imemresp_rdy;

    always_comb begin
        out_pair.inst = reset ? '0 : c_nop;
        out_pair.pc   = '0;
        if (deliver) begin
            out_pair.inst = imemresp_data;
            out_pair.pc   = q_head;
        end
    end

    assign inst_val_F = deliver && imemresp_val;
    assign inst_F     = out_pair.inst;
    assign pc_F       = out_pair.pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc     <= p_reset_vector;
            inflight_cnt <= '0;
            drop_cnt     <= '0;
        end else begin
            if (req_fire)          fetch_pc <= imemreq_addr + 32'd4;
            else if (redirect_val) fetch_pc <= redirect_target;

            inflight_cnt <= inflight_cnt + cnt_t'(req_fire) - cnt_t'(resp_fire);

            // Requests issued this cycle already target the new path, so only
            // older ones still outstanding after this cycle's response are stale.
            if (redirect_val)
                drop_cnt <= inflight_cnt - cnt_t'(resp_fire);
            else if (drop_cnt != '0 && resp_fire)
                drop_cnt <= drop_cnt - cnt_t'(1);
        end
    end

    proc_fetch_pc_queue #(
        .p_depth (p_max_inflight)
    ) u_pc_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (req_fire),
        .push_data (imemreq_addr),
        .pop       (resp_fire),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    logic unused_ok;
    assign unused_ok = q_empty;

endmodule
